// File: rtl/pll_reset_sequencer.sv
// Consumer-side sequencer for a Gowin rPLL. It runs on the reference clock, qualifies the asynchronous lock signal
// and releases a clean system reset once lock has been stable. It also pulses the PLL reset when lock never arrives.
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int PLL_RST_CYCLES = 16,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] lost_count
);

    localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        PLL_RST,
        STABLE,
        HOLD,
        RUN
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]       r_lost_count, w_lost_nxt;
    logic             r_lk_s1, r_lk_s2;
    logic             r_pll_reset, r_sys_reset, r_ready;
    logic             w_cnt_zero;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? 8'hFF : val + 8'd1;
    endfunction

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lk_s1 <= 1'b0;
            r_lk_s2 <= 1'b0;
        end else begin
            r_lk_s1 <= pll_lock;
            r_lk_s2 <= r_lk_s1;
        end
    end

    // Every state entry reloads the shared down-counter; lock loss takes priority over counter expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 1'b1;
        w_lost_nxt  = r_lost_count;
        case (r_state)
            WAIT_LOCK: begin
                if (r_lk_s2) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = LD_STABLE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = PLL_RST;
                    w_cnt_nxt   = LD_PLL_RST;
                end
            end
            PLL_RST: begin
                if (w_cnt_zero) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TIMEOUT;
                end
            end
            STABLE: begin
                if (!r_lk_s2) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TIMEOUT;
                end else if (w_cnt_zero) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = LD_HOLD;
                end
            end
            HOLD: begin
                if (!r_lk_s2) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TIMEOUT;
                end else if (w_cnt_zero) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt;
                if (!r_lk_s2) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TIMEOUT;
                    w_lost_nxt  = sat_inc8(r_lost_count);
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = LD_TIMEOUT;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= LD_TIMEOUT;
            r_lost_count <= 8'd0;
            r_pll_reset  <= 1'b0;
            r_sys_reset  <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lost_count <= w_lost_nxt;
            r_pll_reset  <= (w_state_nxt == PLL_RST);
            r_sys_reset  <= (w_state_nxt != RUN);
            r_ready      <= (w_state_nxt == RUN);
        end
    end

    assign pll_reset  = r_pll_reset;
    assign sys_reset  = r_sys_reset;
    assign ready      = r_ready;
    assign lost_count = r_lost_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with small cycle parameters. A vector table and hand-written sequences push
// expected outputs into a scoreboard, and a checker compares them against the DUT one time unit after each edge.
module tb_pll_reset_sequencer;

    localparam int STB = 8;
    localparam int HLD = 4;
    localparam int TMO = 32;
    localparam int PRC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] lost_count;

    pll_reset_sequencer #(
        .STABLE_CYCLES (STB),
        .HOLD_CYCLES   (HLD),
        .TIMEOUT_CYCLES(TMO),
        .PLL_RST_CYCLES(PRC),
        .CNT_W         (24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .sys_reset (sys_reset),
        .ready     (ready),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lock;
        int         cycles;
        logic       pr;
        logic       sr;
        logic       rdy;
        logic [7:0] lc;
        string      name;
    } vec_t;

    typedef struct {
        int         due;
        logic       pr;
        logic       sr;
        logic       rdy;
        logic [7:0] lc;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    vec_t tbl[19];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic lock, input int n, input logic pr, input logic sr,
                                input logic rdy, input logic [7:0] lc, input string nm);
        vec_t v;
        v.lock = lock; v.cycles = n; v.pr = pr; v.sr = sr; v.rdy = rdy; v.lc = lc; v.name = nm;
        return v;
    endfunction

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic chk(input string name, input logic pr, input logic sr, input logic rdy, input logic [7:0] lc);
        n_checks++;
        if ({pll_reset, sys_reset, ready, lost_count} !== {pr, sr, rdy, lc}) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got pll_reset=%b sys_reset=%b ready=%b lost=%0d, expected pll_reset=%b sys_reset=%b ready=%b lost=%0d",
                     name, cyc, pll_reset, sys_reset, ready, lost_count, pr, sr, rdy, lc);
        end
    endtask

    task automatic push(input int n, input logic pr, input logic sr, input logic rdy,
                        input logic [7:0] lc, input string name);
        exp_t e;
        e.due = cyc + n; e.pr = pr; e.sr = sr; e.rdy = rdy; e.lc = lc; e.name = name;
        sb.push_back(e);
    endtask

    // Drive lock for n cycles starting at a falling edge; outputs are expected after the n-th rising edge.
    task automatic drive(input logic lock, input int n, input logic pr, input logic sr, input logic rdy,
                         input logic [7:0] lc, input string name);
        pll_lock = lock;
        push(n, pr, sr, rdy, lc, name);
        repeat (n) @(negedge clk);
    endtask

    always begin : sb_check
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e_cur = sb.pop_front();
            chk(e_cur.name, e_cur.pr, e_cur.sr, e_cur.rdy, e_cur.lc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(1'b0, 20, 1'b0, 1'b1, 1'b0, 8'd0, "wait_lock_idle");
        tbl[1]  = mk(1'b0, 12, 1'b1, 1'b1, 1'b0, 8'd0, "pll_rst_start");
        tbl[2]  = mk(1'b0,  2, 1'b1, 1'b1, 1'b0, 8'd0, "pll_rst_last");
        tbl[3]  = mk(1'b0,  1, 1'b0, 1'b1, 1'b0, 8'd0, "pll_rst_end");
        tbl[4]  = mk(1'b0, 31, 1'b0, 1'b1, 1'b0, 8'd0, "wait2_before_pulse");
        tbl[5]  = mk(1'b0,  1, 1'b1, 1'b1, 1'b0, 8'd0, "pll_rst_repeat");
        tbl[6]  = mk(1'b0,  3, 1'b0, 1'b1, 1'b0, 8'd0, "pll_rst_end2");
        tbl[7]  = mk(1'b1, 14, 1'b0, 1'b1, 1'b0, 8'd0, "qualify_not_yet");
        tbl[8]  = mk(1'b1,  1, 1'b0, 1'b0, 1'b1, 8'd0, "run_entry");
        tbl[9]  = mk(1'b1,  5, 1'b0, 1'b0, 1'b1, 8'd0, "run_hold");
        tbl[10] = mk(1'b0,  2, 1'b0, 1'b0, 1'b1, 8'd0, "loss_sync_delay");
        tbl[11] = mk(1'b0,  1, 1'b0, 1'b1, 1'b0, 8'd1, "loss_detect");
        tbl[12] = mk(1'b1, 14, 1'b0, 1'b1, 1'b0, 8'd1, "relock_not_yet");
        tbl[13] = mk(1'b1,  1, 1'b0, 1'b0, 1'b1, 8'd1, "relock_run");
        tbl[14] = mk(1'b0,  3, 1'b0, 1'b1, 1'b0, 8'd2, "second_loss");
        tbl[15] = mk(1'b1,  6, 1'b0, 1'b1, 1'b0, 8'd2, "stable_partial");
        tbl[16] = mk(1'b0,  1, 1'b0, 1'b1, 1'b0, 8'd2, "glitch_low");
        tbl[17] = mk(1'b1, 14, 1'b0, 1'b1, 1'b0, 8'd2, "requalify_not_yet");
        tbl[18] = mk(1'b1,  1, 1'b0, 1'b0, 1'b1, 8'd2, "requalify_run");

        reset = 1'b1;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_values", 1'b0, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++)
            drive(tbl[i].lock, tbl[i].cycles, tbl[i].pr, tbl[i].sr, tbl[i].rdy, tbl[i].lc, tbl[i].name);

        // Lock lost exactly as the HOLD counter expires: must fall back, not enter RUN, and not count a loss.
        drive(1'b0,  3, 1'b0, 1'b1, 1'b0, 8'd3, "loss3");
        drive(1'b1, 12, 1'b0, 1'b1, 1'b0, 8'd3, "hold_before_drop");
        drive(1'b0,  3, 1'b0, 1'b1, 1'b0, 8'd3, "hold_zero_loss_wins");
        drive(1'b0,  5, 1'b0, 1'b1, 1'b0, 8'd3, "stays_waiting");

        // Saturation of the loss counter.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_clears_lost", 1'b0, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;
        drive(1'b1, 15, 1'b0, 1'b0, 1'b1, 8'd0, "sat_first_run");
        for (int i = 0; i < 300; i++) begin
            drive(1'b0,  3, 1'b0, 1'b1, 1'b0, sat8(i + 1), "sat_loss");
            drive(1'b1, 15, 1'b0, 1'b0, 1'b1, sat8(i + 1), "sat_run");
        end

        // Asynchronous reset from RUN with a saturated counter, then in the middle of a PLL reset pulse.
        pll_lock = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_from_run", 1'b0, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32, 1'b1, 1'b1, 1'b0, 8'd0, "pulse_start");
        drive(1'b0,  1, 1'b1, 1'b1, 1'b0, 8'd0, "pulse_second");
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_mid_pulse", 1'b0, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        chk("reset_held", 1'b0, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;
        drive(1'b0, 31, 1'b0, 1'b1, 1'b0, 8'd0, "after_reset_wait");
        drive(1'b0,  1, 1'b1, 1'b1, 1'b0, 8'd0, "after_reset_pulse");

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
